// File: rtl/lamp_sequencer.sv
// ============================================================================
// Module      : lamp_sequencer
// Description : Timed RED->GREEN->YELLOW lamp sequencer with pedestrian
//               request/acknowledge; optional FLASH state via the
//               LAMP_FLASH_MODE_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lamp_sequencer #(
   parameter int RED_CYC = 8,
   parameter int GRN_CYC = 10,
   parameter int YEL_CYC = 3,
   parameter int MIN_GRN = 4,
   parameter int CNT_W   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       ped_req,
`ifdef LAMP_FLASH_MODE_EN
   input  logic       flash,
`endif
   output logic       ped_ack,
   output logic [2:0] light,
   output logic [1:0] phase,
   output logic       phase_done
);

   typedef enum logic [1:0] {
      S_RED   = 2'd0,
      S_GRN   = 2'd1,
      S_YEL   = 2'd2,
      S_FLASH = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_red_last = CNT_W'(RED_CYC - 1);
   localparam logic [CNT_W-1:0] c_grn_last = CNT_W'(GRN_CYC - 1);
   localparam logic [CNT_W-1:0] c_yel_last = CNT_W'(YEL_CYC - 1);
   localparam logic [CNT_W-1:0] c_min_last = CNT_W'(MIN_GRN - 1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_light, w_light_nxt;
   logic             r_pend, w_pend_nxt;
   logic             r_req_q;
   logic             r_ack, w_ack_nxt;
   logic             r_done, w_done_nxt;
   logic             w_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RED;
         r_cnt   <= '0;
         r_light <= 3'b100;
         r_pend  <= 1'b0;
         r_req_q <= 1'b0;
         r_ack   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_light <= w_light_nxt;
         r_pend  <= w_pend_nxt;
         r_req_q <= ped_req;
         r_ack   <= w_ack_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_light_nxt = r_light;
      w_ack_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      w_rise      = ped_req & ~r_req_q;
      w_pend_nxt  = r_pend | w_rise;
`ifdef LAMP_FLASH_MODE_EN
      if (flash) begin
         if (r_state != S_FLASH) begin
            w_state_nxt = S_FLASH;
            w_cnt_nxt   = '0;
            w_light_nxt = 3'b010;
            w_done_nxt  = 1'b1;
         end else if (r_cnt == c_yel_last) begin
            w_cnt_nxt   = '0;
            w_light_nxt = r_light ^ 3'b010;
         end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
         end
      end else if (r_state == S_FLASH) begin
         w_state_nxt = S_RED;
         w_cnt_nxt   = '0;
         w_light_nxt = 3'b100;
         w_done_nxt  = 1'b1;
      end else
`endif
      if (en) begin
         w_cnt_nxt = r_cnt + 1'b1;
         unique case (r_state)
            S_RED: begin
               if (r_cnt == c_red_last) begin
                  w_state_nxt = S_GRN;
                  w_cnt_nxt   = '0;
                  w_light_nxt = 3'b001;
                  w_done_nxt  = 1'b1;
               end
            end
            S_GRN: begin
               // A single exit covers both the natural and the early case
               if ((r_cnt == c_grn_last) || (r_pend && (r_cnt >= c_min_last))) begin
                  w_state_nxt = S_YEL;
                  w_cnt_nxt   = '0;
                  w_light_nxt = 3'b010;
                  w_done_nxt  = 1'b1;
               end
            end
            S_YEL: begin
               if (r_cnt == c_yel_last) begin
                  w_state_nxt = S_RED;
                  w_cnt_nxt   = '0;
                  w_light_nxt = 3'b100;
                  w_done_nxt  = 1'b1;
                  if (r_pend) begin
                     w_ack_nxt  = 1'b1;
                     w_pend_nxt = w_rise;
                  end
               end
            end
            default: begin
               w_state_nxt = S_RED;
               w_cnt_nxt   = '0;
               w_light_nxt = 3'b100;
               w_done_nxt  = 1'b1;
            end
         endcase
      end
   end

   assign light      = r_light;
   assign phase      = r_state;
   assign ped_ack    = r_ack;
   assign phase_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_lamp_sequencer.sv
// ============================================================================
// Module      : tb_lamp_sequencer
// Description : Self-checking bench for lamp_sequencer: directed scenarios with
//               literal expectations plus randomized traffic against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lamp_sequencer;

   localparam int RED_CYC = 8;
   localparam int GRN_CYC = 10;
   localparam int YEL_CYC = 3;
   localparam int MIN_GRN = 4;
   localparam int CNT_W   = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b1;
   logic       ped_req = 1'b0;
   logic       ped_ack;
   logic [2:0] light;
   logic [1:0] phase;
   logic       phase_done;
`ifdef LAMP_FLASH_MODE_EN
   logic       flash = 1'b0;
`endif

   int tests = 0;
   int fails = 0;

   // Model: current phase, enabled cycles spent in it, request bookkeeping
   int m_phase, m_age;
   bit m_pend, m_req_prev, m_ack, m_done;

   lamp_sequencer #(
      .RED_CYC(RED_CYC), .GRN_CYC(GRN_CYC), .YEL_CYC(YEL_CYC),
      .MIN_GRN(MIN_GRN), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .ped_req(ped_req),
`ifdef LAMP_FLASH_MODE_EN
      .flash(flash),
`endif
      .ped_ack(ped_ack),
      .light(light),
      .phase(phase),
      .phase_done(phase_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dwell(input int p);
      return (p == 0) ? RED_CYC : (p == 1) ? GRN_CYC : YEL_CYC;
   endfunction

   function automatic logic [2:0] lamp(input int p);
      return (p == 0) ? 3'b100 : (p == 1) ? 3'b001 : 3'b010;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_age = 0; m_pend = 0; m_req_prev = 0; m_ack = 0; m_done = 0;
   endtask

   task automatic model_step();
      bit rise, leave, served;
      rise = ped_req && !m_req_prev;
      m_req_prev = ped_req;
      m_ack = 0; m_done = 0; served = 0;
      if (en) begin
         leave = (m_age + 1 >= dwell(m_phase)) ||
                 (m_phase == 1 && m_pend && m_age + 1 >= MIN_GRN);
         if (leave) begin
            if (m_phase == 2 && m_pend) begin
               m_ack = 1; served = 1;
            end
            m_phase = (m_phase + 1) % 3;
            m_age = 0;
            m_done = 1;
         end else begin
            m_age++;
         end
      end
      m_pend = served ? rise : (m_pend || rise);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         check("model_light", 8'(light), 8'(lamp(m_phase)));
         check("model_phase", 8'(phase), 8'(m_phase));
         check("model_ped_ack", 8'(ped_ack), 8'(m_ack));
         check("model_phase_done", 8'(phase_done), 8'(m_done));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int acks;
      #1 rst_n = 1'b0;
      tick(2);
      check("reset_light", 8'(light), 8'h4);
      check("reset_phase", 8'(phase), 8'h0);
      check("reset_ack", 8'(ped_ack), 8'h0);
      check("reset_done", 8'(phase_done), 8'h0);
      rst_n = 1'b1;

      // Full default period 8/10/3
      for (int i = 1; i <= 21; i++) begin
         tick(1);
         if (i == 7)  check("t1_red_end", 8'(light), 8'h4);
         if (i == 8)  begin check("t1_green", 8'(light), 8'h1); check("t1_done8", 8'(phase_done), 8'h1); end
         if (i == 9)  check("t1_done_clear", 8'(phase_done), 8'h0);
         if (i == 17) check("t1_green_end", 8'(light), 8'h1);
         if (i == 18) begin check("t1_yellow", 8'(light), 8'h2); check("t1_done18", 8'(phase_done), 8'h1); end
         if (i == 20) check("t1_yellow_end", 8'(light), 8'h2);
         if (i == 21) begin check("t1_red", 8'(light), 8'h4); check("t1_done21", 8'(phase_done), 8'h1); end
      end

      // Request at GREEN cnt=1, held high
      tick(8);
      check("t3_green_entry", 8'(light), 8'h1);
      tick(1);
      ped_req = 1'b1;
      tick(2);
      check("t3_green_cnt3", 8'(light), 8'h1);
      tick(1);
      check("t3_early_yellow", 8'(light), 8'h2);
      tick(2);
      check("t3_yellow_end", 8'(light), 8'h2);
      tick(1);
      check("t3_red", 8'(light), 8'h4);
      check("t3_ack", 8'(ped_ack), 8'h1);
      tick(1);
      check("t3_ack_one_cycle", 8'(ped_ack), 8'h0);
      acks = 0;
      for (int i = 0; i < 21; i++) begin
         tick(1);
         if (ped_ack) acks++;
      end
      check("t3_no_second_ack", 8'(acks), 8'h0);
      ped_req = 1'b0;

      // Request pulse at RED cnt=2 shortens the next GREEN
      tick(1);
      ped_req = 1'b1;
      tick(1);
      ped_req = 1'b0;
      tick(5);
      check("t4_green_entry", 8'(light), 8'h1);
      tick(3);
      check("t4_green_last", 8'(light), 8'h1);
      tick(1);
      check("t4_yellow", 8'(light), 8'h2);
      tick(3);
      check("t4_red", 8'(light), 8'h4);
      check("t4_ack", 8'(ped_ack), 8'h1);
      tick(1);
      check("t4_ack_clear", 8'(ped_ack), 8'h0);

      // Freeze for 5 cycles at GREEN cnt=4
      tick(7);
      check("t2_green_entry", 8'(light), 8'h1);
      tick(4);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("t2_frozen_light", 8'(light), 8'h1);
         check("t2_frozen_done", 8'(phase_done), 8'h0);
      end
      en = 1'b1;
      tick(5);
      check("t2_green_still", 8'(light), 8'h1);
      tick(1);
      check("t2_yellow_after_15", 8'(light), 8'h2);

      // Asynchronous reset mid-YELLOW with a pending request
      tick(1);
      ped_req = 1'b1;
      tick(1);
      ped_req = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t5_async_light", 8'(light), 8'h4);
      check("t5_async_phase", 8'(phase), 8'h0);
      tick(2);
      rst_n = 1'b1;
      acks = 0;
      for (int i = 1; i <= 21; i++) begin
         tick(1);
         if (ped_ack) acks++;
         if (i == 8)  check("t5_green", 8'(light), 8'h1);
         if (i == 17) check("t5_full_green", 8'(light), 8'h1);
         if (i == 18) check("t5_yellow", 8'(light), 8'h2);
         if (i == 21) check("t5_red", 8'(light), 8'h4);
      end
      check("t5_no_ack", 8'(acks), 8'h0);

      // Randomized traffic checked by the model
      for (int i = 0; i < 3000; i++) begin
         tick(1);
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
         en = ($urandom_range(0, 99) < 85);
         if ($urandom_range(0, 99) < 15) ped_req = ~ped_req;
      end
      rst_n = 1'b1;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
